// File: rtl/frame_checksum_pkg.sv
// Shared definitions for the frame checksum checker: state encoding, default key, error counter width.
// No logic; types and constants only.
// Imported by the accumulator and the top.
package frame_checksum_pkg;

    localparam logic [1:0] S_DATA   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_RESULT = 2'd2;

    typedef enum logic [1:0] {
        ST_DATA   = S_DATA,
        ST_CHECK  = S_CHECK,
        ST_RESULT = S_RESULT
    } state_t;

    localparam logic [7:0] CHK_KEY_DEFAULT = 8'h37;
    localparam int         ERR_CNT_W       = 16;

    // Word counter width: max(1, clog2(n)).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_checksum_acc.sv
// XOR accumulator seeded with KEY; load has priority over fold.
// Latency: result of a fold visible the cycle after the fold edge.
// Backpressure: none; the caller gates fold with its own transfer condition.
module frame_checksum_acc
    import frame_checksum_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] KEY   = WIDTH'(CHK_KEY_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             fold,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= KEY;
        end else if (load) begin
            acc <= KEY;
        end else if (fold) begin
            acc <= acc ^ word;
        end
    end

endmodule

// File: rtl/frame_checksum.sv
// Frame checksum checker: folds FRAME_LEN words into a KEY-seeded XOR and compares with a trailing check word.
// Latency: res_valid/res_ok one cycle after the check word is accepted; FRAME_LEN+2 cycles per frame.
// Backpressure: in_ready drops for the single result cycle only. Optional err_cnt under FRAME_CHECKSUM_ERRCNT_EN.
module frame_checksum
    import frame_checksum_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] KEY       = WIDTH'(CHK_KEY_DEFAULT),
    parameter int               FRAME_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 res_valid,
    output logic                 res_ok
`ifdef FRAME_CHECKSUM_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int            CW       = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic             xfer;
    logic             acc_load;
    logic             acc_fold;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             ok_upd;

    assign xfer      = in_valid & in_ready;
    assign res_valid = (state == ST_RESULT);

    frame_checksum_acc #(
        .WIDTH (WIDTH),
        .KEY   (KEY)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (acc_load),
        .fold  (acc_fold),
        .word  (in_data),
        .acc   (acc)
    );

    always_comb begin
        state_nxt = state;
        acc_load  = 1'b0;
        acc_fold  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        ok_upd    = 1'b0;
        case (state)
            ST_DATA: begin
                // clear wins over a simultaneous transfer; the word is dropped
                if (clear) begin
                    acc_load = 1'b1;
                    cnt_clr  = 1'b1;
                end else if (xfer) begin
                    acc_fold = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_CHECK;
                        cnt_clr   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (clear) begin
                    state_nxt = ST_DATA;
                    acc_load  = 1'b1;
                    cnt_clr   = 1'b1;
                end else if (xfer) begin
                    state_nxt = ST_RESULT;
                    ok_upd    = 1'b1;
                end
            end
            ST_RESULT: begin
                state_nxt = ST_DATA;
                acc_load  = 1'b1;
            end
            default: begin
                state_nxt = ST_DATA;
                acc_load  = 1'b1;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_DATA;
            cnt      <= '0;
            in_ready <= 1'b0;
            res_ok   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            // Registered ready: low exactly while the result is being reported
            in_ready <= (state_nxt != ST_RESULT);
            if (ok_upd) begin
                res_ok <= (in_data == acc);
            end
        end
    end

`ifdef FRAME_CHECKSUM_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (res_valid && !res_ok && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule
